// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
// wb_ctrl_t packs the writeback control bits so that RegWrite sits at bit 0
// and MemtoReg at bit 1, matching the raw 2-bit control bus from MEM.
package mips_pipe_pkg;

  localparam int WB_REGWRITE_BIT = 0;
  localparam int WB_MEMTOREG_BIT = 1;

  // Register index of the hard-wired zero register.
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic mem_to_reg;  // bit 1: select memory read data for writeback
    logic reg_write;   // bit 0: write the register file
  } wb_ctrl_t;

  // Writeback source select: memory data when mem_to_reg is set, else ALU.
  function automatic logic [31:0] wb_select32(input wb_ctrl_t ctrl,
                                              input logic [31:0] alu,
                                              input logic [31:0] mem);
    return ctrl.mem_to_reg ? mem : alu;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
// The main entry drives the outputs; the skid entry catches the one beat that
// can arrive after a downstream stall because in_ready is registered.
// Strict FIFO order. flush clears both entries and outranks accept/release.
// Synchronous active-high reset clears valid bits and payload registers.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic [W-1:0] main_data_q,  main_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         in_ready_q,   in_ready_d;

  logic push;
  logic pop;

  // Handshake qualifiers for this cycle.
  always_comb begin
    push = in_valid && in_ready_q;
    pop  = main_valid_q && out_ready;
  end

  // Next-state: drain skid into main on release, then place any accepted beat
  // in the first free entry so ordering stays first-in first-out.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // if/else tree leaves one unassigned and no latch is inferred.
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Valid bits only; payload registers keep their last loaded value.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (pop) begin
        if (skid_valid_q) begin
          main_data_d  = skid_data_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      if (push) begin
        if (!main_valid_d) begin
          main_data_d  = in_data;
          main_valid_d = 1'b1;
        end else if (!skid_valid_d) begin
          skid_data_d  = in_data;
          skid_valid_d = 1'b1;
        end
      end
    end

    // Ready next cycle exactly when the skid entry will be free.
    in_ready_d = !skid_valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: payload registers are reset as well as the valid bits, so the
      // held outputs read zero after reset; with only two entries this is a
      // handful of flops, unlike a RAM-backed FIFO.
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Outputs come straight from registers; no input-to-output path.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = main_valid_q;
    out_data  = main_data_q;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers the MEM-stage beat through a 2-entry skid
// buffer and drives the writeback mux, zero-register guard and write enable.
// Optional feature macro: MEM_WB_FWD_EN adds fwd_valid/fwd_reg/fwd_data for
// the hazard/forwarding unit. Without it those ports and their logic vanish.
module mem_wb_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int ZERO_GUARD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_wb_ctrl,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [REG_AW-1:0] in_write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_read_data,
  output logic [REG_AW-1:0] out_write_reg,
  output logic [DATA_W-1:0] out_write_data
`ifdef MEM_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int PW = 2 + 2 * DATA_W + REG_AW;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;
  wb_ctrl_t      out_ctrl;
  logic          is_zero_reg;

  assign in_payload = {in_wb_ctrl, in_alu_result, in_read_data, in_write_reg};

  pipe_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {out_ctrl, out_alu_result, out_read_data, out_write_reg} = out_payload;

  // Writeback mux and gated write enable, from main-entry registers only.
  always_comb begin
    is_zero_reg    = (ZERO_GUARD != 0) && (out_write_reg == REG_AW'(ZERO_REG));
    out_mem_to_reg = out_ctrl.mem_to_reg;
    out_reg_write  = out_valid && out_ctrl.reg_write && !is_zero_reg;
    out_write_data = out_ctrl.mem_to_reg ? out_read_data : out_alu_result;
  end

`ifdef MEM_WB_FWD_EN
  // Forwarding view of the beat about to be written back.
  always_comb begin
    fwd_valid = out_reg_write;
    fwd_reg   = out_write_reg;
    fwd_data  = out_write_data;
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios followed by a
// random phase, all compared each cycle against a queue-based model of a
// two-deep FIFO stage.
module tb_mem_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_wb_ctrl;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_read_data;
  logic [REG_AW-1:0] in_write_reg;
  logic              out_valid;
  logic              out_ready;
  logic              out_reg_write;
  logic              out_mem_to_reg;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_read_data;
  logic [REG_AW-1:0] out_write_reg;
  logic [DATA_W-1:0] out_write_data;
`ifdef MEM_WB_FWD_EN
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_reg;
  logic [DATA_W-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DATA_W     (DATA_W),
    .REG_AW     (REG_AW),
    .ZERO_GUARD (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wb_ctrl     (in_wb_ctrl),
    .in_alu_result  (in_alu_result),
    .in_read_data   (in_read_data),
    .in_write_reg   (in_write_reg),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_reg_write  (out_reg_write),
    .out_mem_to_reg (out_mem_to_reg),
    .out_alu_result (out_alu_result),
    .out_read_data  (out_read_data),
    .out_write_reg  (out_write_reg),
    .out_write_data (out_write_data)
`ifdef MEM_WB_FWD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_reg        (fwd_reg),
    .fwd_data       (fwd_data)
`endif
  );

  typedef struct packed {
    logic [1:0]        ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd;
    logic [REG_AW-1:0] rg;
  } beat_t;

  // Reference model: FIFO of at most two beats, ready flag, last front beat.
  beat_t q[$];
  beat_t held;
  logic  ready_exp;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_update();
    beat_t cur;
    bit    do_pop;
    bit    do_push;
    cur = '{ctrl: in_wb_ctrl, alu: in_alu_result, rd: in_read_data, rg: in_write_reg};
    if (rst) begin
      q.delete();
      ready_exp = 1'b0;
      held      = '0;
    end else if (flush) begin
      q.delete();
      ready_exp = 1'b1;
    end else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && ready_exp;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(cur);
      ready_exp = (q.size() < 2);
    end
    if (q.size() > 0) held = q[0];
  endtask

  task automatic check_all();
    logic             v;
    logic [DATA_W-1:0] wd;
    logic             we;
    v  = (q.size() > 0);
    wd = held.ctrl[1] ? held.rd : held.alu;
    we = v && held.ctrl[0] && (held.rg != 0);
    check("out_valid",      out_valid,      v);
    check("in_ready",       in_ready,       ready_exp);
    check("out_write_reg",  out_write_reg,  held.rg);
    check("out_alu_result", out_alu_result, held.alu);
    check("out_read_data",  out_read_data,  held.rd);
    check("out_mem_to_reg", out_mem_to_reg, held.ctrl[1]);
    check("out_write_data", out_write_data, wd);
    check("out_reg_write",  out_reg_write,  we);
`ifdef MEM_WB_FWD_EN
    check("fwd_valid", fwd_valid, we);
    check("fwd_reg",   fwd_reg,   held.rg);
    check("fwd_data",  fwd_data,  wd);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive_beat(input logic [1:0] c, input logic [31:0] a,
                            input logic [31:0] r, input logic [4:0] g);
    in_wb_ctrl    = c;
    in_alu_result = a;
    in_read_data  = r;
    in_write_reg  = g;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_beat(2'b00, 32'h0, 32'h0, 5'd0);
    ready_exp = 1'b0;
    held      = '0;

    // 1: reset held for two cycles, then released.
    step();
    check("rst_in_ready", in_ready, 1'b0);
    step();
    check("rst_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_alu", out_alu_result, '0);
    check("post_rst_reg_write", out_reg_write, 1'b0);

    // 2: streaming, one beat per cycle, no bubbles.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_beat(2'b01, 32'h100 + i, 32'hA000 + i, 5'(i));
      step();
      check("stream_valid", out_valid, 1'b1);
      check("stream_reg", out_write_reg, 5'(i));
      check("stream_alu", out_alu_result, 32'h100 + i);
    end
    in_valid = 1'b0;
    step();

    // 3: stall with three beats offered; two held, third waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_beat(2'b01, 32'h200 + k, 32'h0, 5'(10 + k));
      step();
    end
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_head", out_write_reg, 5'd10);
    out_ready = 1'b1;
    step();
    check("drain_1", out_write_reg, 5'd11);
    step();
    check("drain_2", out_write_reg, 5'd12);
    in_valid = 1'b0;
    step();
    check("drain_empty", out_valid, 1'b0);

    // 4: writeback mux and zero-register guard.
    in_valid = 1'b1;
    drive_beat(2'b11, 32'h1234, 32'hDEADBEEF, 5'd5);
    step();
    check("mux_data", out_write_data, 32'hDEADBEEF);
    check("mux_we", out_reg_write, 1'b1);
    drive_beat(2'b11, 32'h1234, 32'hDEADBEEF, 5'd0);
    step();
    check("guard_we", out_reg_write, 1'b0);
    in_valid = 1'b0;
    step();

    // 5a: flush with both entries full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_beat(2'b01, 32'h301, 32'h0, 5'd20);
    step();
    drive_beat(2'b01, 32'h302, 32'h0, 5'd21);
    step();
    drive_beat(2'b01, 32'h3F1, 32'h0, 5'd31);
    flush = 1'b1;
    step();
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    // 5b: flush while a beat is accepted; that beat is discarded.
    flush = 1'b0;
    drive_beat(2'b01, 32'h303, 32'h0, 5'd22);
    step();
    drive_beat(2'b01, 32'h3F2, 32'h0, 5'd30);
    flush = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("flushed_gone", out_valid, 1'b0);
    end

`ifdef MEM_WB_FWD_EN
    // 6: forwarding view while the beat is held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_beat(2'b01, 32'h55, 32'h0, 5'd9);
    step();
    in_valid = 1'b0;
    step();
    check("fwd_valid_d", fwd_valid, 1'b1);
    check("fwd_reg_d", fwd_reg, 5'd9);
    check("fwd_data_d", fwd_data, 32'h55);
    out_ready = 1'b1;
    step();
`endif

    // Random phase: traffic, stalls, occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      drive_beat(2'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
